// File: rtl/vscale_htif_pcr_client.sv
// vscale_htif_pcr_client
//
// Host-side requester for the HTIF PCR port of the CSR file. Host CSR commands are queued in a
// small request FIFO and issued one at a time on the htif_pcr_req_* channel. Each response is
// captured and held for the host until it is accepted. A response timeout guards against a hung
// CSR port. A response that arrives after its timeout is swallowed before anything new issues.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   host_req_*            : host command in (valid/ready, rw, addr, data)
//   host_resp_*           : held response out (valid/ready, data, timeout flag)
//   htif_pcr_req_*        : request to the CSR file (valid/ready, rw, addr, data from FIFO head)
//   htif_pcr_resp_*       : response from the CSR file (valid/ready, data)
module vscale_htif_pcr_client #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CSR_ADDR_WIDTH = 12,
  parameter int unsigned HTIF_PCR_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  // host command channel
  input  logic                      host_req_valid,
  output logic                      host_req_ready,
  input  logic                      host_req_rw,
  input  logic [CSR_ADDR_WIDTH-1:0] host_req_addr,
  input  logic [HTIF_PCR_WIDTH-1:0] host_req_data,
  // host response channel
  output logic                      host_resp_valid,
  input  logic                      host_resp_ready,
  output logic [HTIF_PCR_WIDTH-1:0] host_resp_data,
  output logic                      host_resp_timeout,
  // CSR file request channel
  output logic                      htif_pcr_req_valid,
  input  logic                      htif_pcr_req_ready,
  output logic                      htif_pcr_req_rw,
  output logic [CSR_ADDR_WIDTH-1:0] htif_pcr_req_addr,
  output logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data,
  // CSR file response channel
  input  logic                      htif_pcr_resp_valid,
  output logic                      htif_pcr_resp_ready,
  input  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned TcntW  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned EntryW = 1 + CSR_ADDR_WIDTH + HTIF_PCR_WIDTH;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StHold = 2'd2
  } state_e;

  state_e r_state, w_state_d;

  // Request FIFO
  logic [EntryW-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic              w_full, w_empty;
  logic              w_push, w_pop;
  logic [EntryW-1:0] w_head;

  // Transaction tracking
  logic [TcntW-1:0]          r_tcnt;
  logic                      r_stale;
  logic [HTIF_PCR_WIDTH-1:0] r_resp_data;
  logic                      r_resp_to;

  // Decoded control
  logic w_req_valid;
  logic w_resp_ready;
  logic w_hold;
  logic w_resp_hs;
  logic w_resp_take;
  logic w_resp_drop;
  logic w_tcnt_last;
  logic w_timeout;

  assign w_full  = (r_count == CntW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = host_req_valid && !w_full;
  assign w_pop   = w_req_valid && htif_pcr_req_ready;
  assign w_head  = r_mem[r_rd_ptr];

  assign w_resp_hs   = htif_pcr_resp_valid && w_resp_ready;
  // A response seen while stale belongs to the timed-out request and is thrown away.
  assign w_resp_take = w_resp_hs && !r_stale && (r_state == StWait);
  assign w_resp_drop = w_resp_hs && r_stale;
  assign w_tcnt_last = (r_tcnt == TcntW'(TIMEOUT_CYCLES - 1));
  // Response wins over a timeout in the same cycle.
  assign w_timeout   = (r_state == StWait) && !w_resp_take && w_tcnt_last;

  // ---------------------------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {host_req_rw, host_req_addr, host_req_data};
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (w_pop) w_state_d = StWait;
      StWait: if (w_resp_take || w_timeout) w_state_d = StHold;
      StHold: if (host_resp_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_req_valid  = 1'b0;
    w_resp_ready = r_stale;
    w_hold       = 1'b0;
    unique case (r_state)
      StIdle: w_req_valid  = !w_empty && !r_stale;
      StWait: w_resp_ready = 1'b1;
      StHold: w_hold       = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Timeout counter, stale flag and response capture
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tcnt <= '0;
    end else if (w_pop) begin
      r_tcnt <= '0;
    end else if ((r_state == StWait) && !w_resp_take && !w_tcnt_last) begin
      r_tcnt <= r_tcnt + TcntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stale <= 1'b0;
    end else if (w_timeout) begin
      r_stale <= 1'b1;
    end else if (w_resp_drop) begin
      r_stale <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_data <= '0;
      r_resp_to   <= 1'b0;
    end else if (w_resp_take) begin
      r_resp_data <= htif_pcr_resp_data;
      r_resp_to   <= 1'b0;
    end else if (w_timeout) begin
      r_resp_data <= '0;
      r_resp_to   <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------------------------
  assign host_req_ready      = !w_full;
  assign host_resp_valid     = w_hold;
  assign host_resp_data      = r_resp_data;
  assign host_resp_timeout   = r_resp_to;
  assign htif_pcr_req_valid  = w_req_valid;
  assign htif_pcr_req_rw     = w_head[EntryW-1];
  assign htif_pcr_req_addr   = w_head[HTIF_PCR_WIDTH +: CSR_ADDR_WIDTH];
  assign htif_pcr_req_data   = w_head[HTIF_PCR_WIDTH-1:0];
  assign htif_pcr_resp_ready = w_resp_ready;

endmodule

// File: tb/tb_vscale_htif_pcr_client.sv
// Self-checking bench for vscale_htif_pcr_client. A small CSR-file model answers accepted
// requests after an address-dependent delay; a scoreboard queues the expected host response at
// each host push and compares it when the host accepts a response.
module tb_vscale_htif_pcr_client;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_req_valid;
  logic        host_req_ready;
  logic        host_req_rw;
  logic [11:0] host_req_addr;
  logic [63:0] host_req_data;
  logic        host_resp_valid;
  logic        host_resp_ready;
  logic [63:0] host_resp_data;
  logic        host_resp_timeout;
  logic        htif_pcr_req_valid;
  logic        htif_pcr_req_ready;
  logic        htif_pcr_req_rw;
  logic [11:0] htif_pcr_req_addr;
  logic [63:0] htif_pcr_req_data;
  logic        htif_pcr_resp_valid;
  logic        htif_pcr_resp_ready;
  logic [63:0] htif_pcr_resp_data;

  always #5 clk = ~clk;

  vscale_htif_pcr_client #(
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(T),
    .CSR_ADDR_WIDTH(12),
    .HTIF_PCR_WIDTH(64)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .host_req_valid     (host_req_valid),
    .host_req_ready     (host_req_ready),
    .host_req_rw        (host_req_rw),
    .host_req_addr      (host_req_addr),
    .host_req_data      (host_req_data),
    .host_resp_valid    (host_resp_valid),
    .host_resp_ready    (host_resp_ready),
    .host_resp_data     (host_resp_data),
    .host_resp_timeout  (host_resp_timeout),
    .htif_pcr_req_valid (htif_pcr_req_valid),
    .htif_pcr_req_ready (htif_pcr_req_ready),
    .htif_pcr_req_rw    (htif_pcr_req_rw),
    .htif_pcr_req_addr  (htif_pcr_req_addr),
    .htif_pcr_req_data  (htif_pcr_req_data),
    .htif_pcr_resp_valid(htif_pcr_resp_valid),
    .htif_pcr_resp_ready(htif_pcr_resp_ready),
    .htif_pcr_resp_data (htif_pcr_resp_data)
  );

  int          n_err    = 0;
  int          n_checks = 0;
  logic [64:0] exp_q[$];

  // CSR model state
  bit          m_busy = 1'b0;
  int          m_rem  = 0;
  logic [11:0] m_addr = '0;
  logic [63:0] m_data = '0;

  function automatic logic [63:0] reply(logic [11:0] a, logic [63:0] d);
    if (a == 12'h780) return 64'h1234;
    return d ^ 64'hA5A5_0000_0000_0000 ^ {52'd0, a};
  endfunction

  // 0 = never answers; otherwise the response appears d cycles after acceptance.
  function automatic int delay_of(logic [11:0] a);
    if (a[11:8] == 4'hF) return 0;
    if (a == 12'h7C0) return T;
    return 1;
  endfunction

  function automatic logic [64:0] expect_for(logic [11:0] a, logic [63:0] d);
    if (delay_of(a) == 0) return {1'b1, 64'd0};
    return {1'b0, reply(a, d)};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_req_ready"},  64'(host_req_ready), 64'd1);
    check({tag, "_resp_valid"}, 64'(host_resp_valid), 64'd0);
    check({tag, "_resp_data"},  host_resp_data, 64'd0);
    check({tag, "_resp_to"},    64'(host_resp_timeout), 64'd0);
    check({tag, "_pcr_valid"},  64'(htif_pcr_req_valid), 64'd0);
    check({tag, "_pcr_rready"}, 64'(htif_pcr_resp_ready), 64'd0);
    check({tag, "_pcr_rw"},     64'(htif_pcr_req_rw), 64'd0);
    check({tag, "_pcr_addr"},   64'(htif_pcr_req_addr), 64'd0);
    check({tag, "_pcr_data"},   htif_pcr_req_data, 64'd0);
  endtask

  // One clock cycle: observe handshakes at the negedge, step one posedge, update the CSR model.
  task automatic tick();
    bit          req_hs, resp_hs, push, pop;
    logic [11:0] ra;
    logic [63:0] rd;
    logic [64:0] e;
    req_hs  = htif_pcr_req_valid && htif_pcr_req_ready;
    ra      = htif_pcr_req_addr;
    rd      = htif_pcr_req_data;
    resp_hs = htif_pcr_resp_valid && htif_pcr_resp_ready;
    push    = host_req_valid && host_req_ready;
    pop     = host_resp_valid && host_resp_ready;
    if (push) exp_q.push_back(expect_for(host_req_addr, host_req_data));
    if (pop) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_resp", 64'(host_resp_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", host_resp_data, e[63:0]);
        check("sb_timeout", 64'(host_resp_timeout), 64'(e[64]));
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (push) host_req_valid = 1'b0;
    if (resp_hs) begin
      htif_pcr_resp_valid = 1'b0;
      htif_pcr_resp_data  = '0;
    end
    if (req_hs) begin
      m_busy = (delay_of(ra) != 0);
      m_rem  = delay_of(ra) - 1;
      m_addr = ra;
      m_data = rd;
    end else if (m_busy && m_rem > 0) begin
      m_rem--;
    end
    if (m_busy && m_rem == 0) begin
      htif_pcr_resp_valid = 1'b1;
      htif_pcr_resp_data  = reply(m_addr, m_data);
      m_busy              = 1'b0;
    end
  endtask

  task automatic drive_req(logic [11:0] a, logic [63:0] d, logic rw);
    host_req_valid = 1'b1;
    host_req_addr  = a;
    host_req_data  = d;
    host_req_rw    = rw;
  endtask

  task automatic drain(string tag, int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) tick();
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int pushed;
    logic [63:0] held;

    reset               = 1'b1;
    host_req_valid      = 1'b0;
    host_req_rw         = 1'b0;
    host_req_addr       = '0;
    host_req_data       = '0;
    host_resp_ready     = 1'b0;
    htif_pcr_req_ready  = 1'b0;
    htif_pcr_resp_valid = 1'b0;
    htif_pcr_resp_data  = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    reset              = 1'b0;
    host_resp_ready    = 1'b1;
    htif_pcr_req_ready = 1'b1;
    tick();

    // Single read, minimum latency
    drive_req(12'h780, 64'd0, 1'b0);
    check("rd_no_bypass", 64'(htif_pcr_req_valid), 64'd0);
    tick();  // E0 push
    check("rd_req_valid", 64'(htif_pcr_req_valid), 64'd1);
    check("rd_req_addr", 64'(htif_pcr_req_addr), 64'h780);
    tick();  // E1 handshake
    check("rd_wait_no_resp", 64'(host_resp_valid), 64'd0);
    check("rd_wait_rready", 64'(htif_pcr_resp_ready), 64'd1);
    tick();  // E2 capture
    check("rd_resp_valid", 64'(host_resp_valid), 64'd1);
    check("rd_resp_data", host_resp_data, 64'h1234);
    check("rd_resp_to", 64'(host_resp_timeout), 64'd0);
    tick();  // E3 consumed
    check("rd_resp_gone", 64'(host_resp_valid), 64'd0);

    // FIFO full and wrap
    htif_pcr_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(12'(12'h100 + i), 64'(i), 1'(i));
      check("full_ready_before", 64'(host_req_ready), 64'd1);
      tick();
    end
    check("full_ready_dropped", 64'(host_req_ready), 64'd0);
    drive_req(12'h104, 64'd4, 1'b0);
    tick();
    check("full_fifth_blocked", 64'(host_req_ready), 64'd0);
    check("full_fifth_not_queued", 64'(exp_q.size()), 64'd4);
    host_req_valid     = 1'b0;
    htif_pcr_req_ready = 1'b1;
    pushed = 0;
    for (int i = 0; i < 300; i++) begin
      if (!host_req_valid && pushed < 6) drive_req(12'(12'h200 + pushed), 64'(64'h1000 + pushed),
                                                   1'(pushed));
      if (host_req_valid && host_req_ready) pushed++;
      tick();
      if (pushed == 6 && exp_q.size() == 0) break;
    end
    check("wrap_pushed", 64'(pushed), 64'd6);
    check("wrap_drained", 64'(exp_q.size()), 64'd0);

    // Timeout with a second command queued behind it
    host_resp_ready = 1'b0;
    drive_req(12'hF01, 64'h55, 1'b1);
    tick();
    drive_req(12'h301, 64'h3333, 1'b0);
    tick();  // F01 accepted, enters WAIT
    repeat (T - 1) tick();
    check("to_not_early", 64'(host_resp_valid), 64'd0);
    tick();
    check("to_hold", 64'(host_resp_valid), 64'd1);
    check("to_data", host_resp_data, 64'd0);
    check("to_flag", 64'(host_resp_timeout), 64'd1);
    check("to_no_issue_hold", 64'(htif_pcr_req_valid), 64'd0);
    host_resp_ready = 1'b1;
    tick();
    check("to_no_issue_stale", 64'(htif_pcr_req_valid), 64'd0);
    check("to_stale_rready", 64'(htif_pcr_resp_ready), 64'd1);
    tick();
    check("to_still_blocked", 64'(htif_pcr_req_valid), 64'd0);

    // Late response is swallowed, then the queued request runs
    htif_pcr_resp_valid = 1'b1;
    htif_pcr_resp_data  = 64'hDEAD;
    tick();
    check("stale_issue", 64'(htif_pcr_req_valid), 64'd1);
    check("stale_issue_addr", 64'(htif_pcr_req_addr), 64'h301);
    check("stale_cleared", 64'(htif_pcr_resp_ready), 64'd0);
    check("stale_not_held", 64'(host_resp_valid), 64'd0);
    drain("stale_drain", 20);

    // Response lands on the last WAIT cycle
    host_resp_ready = 1'b0;
    drive_req(12'h7C0, 64'h77, 1'b1);
    tick();
    tick();  // accepted
    repeat (T - 1) tick();
    check("col_not_early", 64'(host_resp_valid), 64'd0);
    tick();
    check("col_hold", 64'(host_resp_valid), 64'd1);
    check("col_data", host_resp_data, reply(12'h7C0, 64'h77));
    check("col_flag", 64'(host_resp_timeout), 64'd0);
    check("col_not_stale", 64'(htif_pcr_resp_ready), 64'd0);
    host_resp_ready = 1'b1;
    tick();
    check("col_idle_rready", 64'(htif_pcr_resp_ready), 64'd0);
    drive_req(12'h302, 64'h99, 1'b0);
    tick();
    check("col_next_issues", 64'(htif_pcr_req_valid), 64'd1);
    drain("col_drain", 20);

    // Host backpressure, then reset mid-HOLD
    host_resp_ready = 1'b0;
    drive_req(12'h401, 64'h4444, 1'b0);
    tick();
    tick();
    tick();
    check("bp_hold", 64'(host_resp_valid), 64'd1);
    held   = reply(12'h401, 64'h4444);
    pushed = 0;
    for (int i = 0; i < 20; i++) begin
      if (!host_req_valid && pushed < 3) drive_req(12'(12'h402 + pushed), 64'(pushed), 1'b1);
      if (host_req_valid && host_req_ready) pushed++;
      check("bp_data_stable", host_resp_data, held);
      check("bp_no_issue", 64'(htif_pcr_req_valid), 64'd0);
      tick();
    end
    check("bp_pushed", 64'(pushed), 64'd3);
    host_req_valid = 1'b0;
    reset          = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    m_busy              = 1'b0;
    htif_pcr_resp_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_empty", 64'(htif_pcr_req_valid), 64'd0);
    check("post_rst_ready", 64'(host_req_ready), 64'd1);
    check("post_rst_no_resp", 64'(host_resp_valid), 64'd0);
    host_resp_ready = 1'b1;
    drive_req(12'h500, 64'h5, 1'b0);
    tick();
    check("post_rst_issue_addr", 64'(htif_pcr_req_addr), 64'h500);
    drain("post_rst_drain", 20);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
